// File: rtl/main_mem_responder.sv
// main_mem_responder: fixed-latency main-memory model that serves one line
// transfer at a time. It answers 128-bit line fills and writebacks from a cache.
// Build macro: MAIN_MEM_RESP_RANGE_CHECK_EN adds the resp_err output. That
// output flags addresses beyond the stored lines. Without the macro, such
// addresses wrap modulo LINES.
module main_mem_responder #(
   parameter int LATENCY = 4,   // 1..15 cycles from acceptance to response
   parameter int LINES   = 64   // power of two, at least 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   input  logic         req_write,
   input  logic [31:0]  req_addr,
   input  logic [127:0] req_wdata,
   output logic         req_ready,
   output logic         resp_valid,
   output logic [127:0] resp_rdata,
`ifdef MAIN_MEM_RESP_RANGE_CHECK_EN
   output logic         resp_err,
`endif
   output logic         busy
);

   localparam int         IDX_W    = $clog2(LINES);
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               write_q;
   logic [IDX_W-1:0]   idx_q;
   logic [127:0]       wdata_q;
   logic               err_q;
   logic [127:0]       mem_q [LINES];

   logic               accept;
   logic               commit;
   logic               addr_err;
   logic               unused_addr;

`ifdef MAIN_MEM_RESP_RANGE_CHECK_EN
   assign addr_err    = |req_addr[31:IDX_W+4];
   assign unused_addr = ^req_addr[3:0];
`else
   assign addr_err    = 1'b0;
   assign unused_addr = ^{req_addr[31:IDX_W+4], req_addr[3:0]};
`endif

   // A request is taken only while idle and out of reset.
   assign accept = reset && req_valid && (state_q == IDLE);
   // A writeback lands on the RESP edge, unless reset aborts it or the address was rejected.
   assign commit = reset && (state_q == RESP) && write_q && !err_q;

   // State and latency counter; reset forces IDLE and clears the counter.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values, independent of process ordering.
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Capture the request on acceptance; held until the next acceptance.
   always_ff @(posedge clk) begin
      if (accept) begin
         write_q <= req_write;
         idx_q   <= req_addr[IDX_W+3:4];
         wdata_q <= req_wdata;
         err_q   <= addr_err;
      end
   end

   // Line storage; contents survive reset.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset branch. Reset only aborts the
      // transfer in flight, and a reset loop over every line would not map
      // onto RAM.
      if (commit) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   // Next-state logic: IDLE -> WAIT (or RESP when LATENCY=1) -> RESP -> IDLE.
   always_comb begin
      // NOTE: defaults first so that no path through the case leaves a
      // variable unassigned, which would infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode the state; reset gates them so an aborted RESP never strobes.
   always_comb begin
      req_ready  = reset && (state_q == IDLE);
      resp_valid = reset && (state_q == RESP);
      busy       = reset && (state_q != IDLE);
      resp_rdata = '0;
      if (resp_valid && !write_q && !err_q) begin
         resp_rdata = mem_q[idx_q];
      end
`ifdef MAIN_MEM_RESP_RANGE_CHECK_EN
      resp_err   = resp_valid && err_q;
`endif
   end

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder. It runs a LATENCY=4 instance
// against a scoreboard plus a line model. A LATENCY=1 instance covers the
// shortest turnaround. It follows MAIN_MEM_RESP_RANGE_CHECK_EN when that
// macro is defined.
`timescale 1ns/1ps
module tb_main_mem_responder;

   localparam int LAT = 4;
   localparam logic [127:0] D032 = 128'h44443333_22221111_DEADBEEF_00000001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, req_valid, req_write;
   logic [31:0]  req_addr;
   logic [127:0] req_wdata;
   logic         req_ready, resp_valid, busy, resp_err;
   logic [127:0] resp_rdata;

   logic         l1_valid, l1_write;
   logic [31:0]  l1_addr;
   logic [127:0] l1_wdata;
   logic         l1_ready, l1_resp_valid, l1_busy, l1_err;
   logic [127:0] l1_rdata;

`ifndef MAIN_MEM_RESP_RANGE_CHECK_EN
   assign resp_err = 1'b0;
   assign l1_err   = 1'b0;
`endif

   main_mem_responder #(.LATENCY(LAT), .LINES(64)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
`ifdef MAIN_MEM_RESP_RANGE_CHECK_EN
      .resp_err(resp_err),
`endif
      .busy(busy));

   main_mem_responder #(.LATENCY(1), .LINES(64)) dut1 (
      .clk(clk), .reset(reset), .req_valid(l1_valid), .req_write(l1_write),
      .req_addr(l1_addr), .req_wdata(l1_wdata), .req_ready(l1_ready),
      .resp_valid(l1_resp_valid), .resp_rdata(l1_rdata),
`ifdef MAIN_MEM_RESP_RANGE_CHECK_EN
      .resp_err(l1_err),
`endif
      .busy(l1_busy));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_w(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_i(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] pat(input int i);
      return {32'h4444_0000 + i, 32'h3333_0000 + i, 32'h2222_0000 + i, 32'h1111_0000 + i};
   endfunction

   // ---------------- scoreboard and line model ----------------
   typedef struct {
      logic         write;
      logic         err;
      logic [5:0]   idx;
      logic [127:0] wdata;
      logic [127:0] rdata;
      int           due;
   } exp_t;

   exp_t         sb[$];
   logic [127:0] model [64];
   logic [127:0] last_rdata;
   logic         last_err;
   int           n_resp = 0;
   int           cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      if (resp_valid) begin
         if (sb.size() == 0) begin
            check_b("unexpected_resp_valid", resp_valid, 1'b0);
         end else begin
            e = sb.pop_front();
            check_i("resp_cycle", cyc, e.due);
            check_w("resp_rdata", resp_rdata, e.rdata);
`ifdef MAIN_MEM_RESP_RANGE_CHECK_EN
            check_b("resp_err", resp_err, e.err);
`endif
            if (e.write && !e.err) model[e.idx] = e.wdata;
            last_rdata = resp_rdata;
            last_err   = resp_err;
            n_resp++;
         end
      end else begin
         check_w("idle_rdata_zero", resp_rdata, '0);
`ifdef MAIN_MEM_RESP_RANGE_CHECK_EN
         check_b("idle_err_zero", resp_err, 1'b0);
`endif
      end
      if (reset && req_valid && req_ready) begin
         e.write = req_write;
         e.idx   = req_addr[9:4];
         e.wdata = req_wdata;
`ifdef MAIN_MEM_RESP_RANGE_CHECK_EN
         e.err   = |req_addr[31:10];
`else
         e.err   = 1'b0;
`endif
         e.rdata = (e.write || e.err) ? '0 : model[e.idx];
         e.due   = cyc + LAT;
         sb.push_back(e);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic nc;
      @(posedge clk);
      #2;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   task automatic do_req(input logic w, input logic [31:0] a, input logic [127:0] d, output int acc);
      int n = 0;
      nc;
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      smp;
      while (!req_ready && n < 20) begin
         nc; smp; n++;
      end
      check_b("accept_timeout", req_ready, 1'b1);
      acc = cyc;
      nc;
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_drain;
      int n = 0;
      smp;
      while ((sb.size() != 0 || busy) && n < 40) begin
         nc; smp; n++;
      end
      check_i("drain_timeout", sb.size(), 0);
   endtask

   typedef struct {
      logic         w;
      logic [31:0]  addr;
      logic [127:0] wdata;
      logic [127:0] exp_rdata;
      logic         exp_err;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, first, prev;
      logic was;

      // Table: reads carry their expected line, writes expect zero data.
      vecs[0] = '{1'b0, 32'h0000_004C, '0, D032, 1'b0};
      vecs[1] = '{1'b1, 32'h0000_0010, 128'hCAFE0001_CAFE0002_CAFE0003_CAFE0004, '0, 1'b0};
      vecs[2] = '{1'b0, 32'h0000_001F, '0, 128'hCAFE0001_CAFE0002_CAFE0003_CAFE0004, 1'b0};
      vecs[3] = '{1'b1, 32'h0000_03F0, 128'h0BAD_F00D_0000_0000_1234_5678_9ABC_DEF0, '0, 1'b0};
      vecs[4] = '{1'b0, 32'h0000_03F8, '0, 128'h0BAD_F00D_0000_0000_1234_5678_9ABC_DEF0, 1'b0};
`ifdef MAIN_MEM_RESP_RANGE_CHECK_EN
      vecs[5] = '{1'b0, 32'h0000_0400, '0, '0, 1'b1};
      vecs[6] = '{1'b1, 32'h0000_0850, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, '0, 1'b1};
      vecs[7] = '{1'b0, 32'h0000_0050, '0, pat(5), 1'b0};
`else
      vecs[5] = '{1'b0, 32'h0000_0400, '0, pat(0), 1'b0};
      vecs[6] = '{1'b1, 32'h0000_0850, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, '0, 1'b0};
      vecs[7] = '{1'b0, 32'h0000_0050, '0, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, 1'b0};
`endif
      vecs[8] = '{1'b0, 32'h0000_0090, '0, pat(9), 1'b0};

      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      l1_valid = 1'b0; l1_write = 1'b0; l1_addr = '0; l1_wdata = '0;

      // Reset state.
      repeat (3) begin
         smp;
         check_b("rst_req_ready", req_ready, 1'b0);
         check_b("rst_busy", busy, 1'b0);
         check_b("rst_resp_valid", resp_valid, 1'b0);
      end
      nc; reset = 1'b1;
      smp;
      check_b("ready_after_reset", req_ready, 1'b1);

      // Give every line a known pattern.
      for (int i = 0; i < 64; i++) begin
         do_req(1'b1, 32'(i << 4), pat(i), acc);
         wait_drain();
      end

      // Writeback timing: busy for LATENCY cycles, strobe on the last one, then ready.
      do_req(1'b1, 32'h0000_0040, D032, acc);
      for (int k = 1; k <= 5; k++) begin
         smp;
         check_b("wr_busy", busy, k <= 4);
         check_b("wr_req_ready", req_ready, k == 5);
         check_b("wr_resp_valid", resp_valid, k == 4);
         if (k < 5) nc;
      end

      // Table-driven vectors.
      for (int v = 0; v < 9; v++) begin
         prev = n_resp;
         do_req(vecs[v].w, vecs[v].addr, vecs[v].wdata, acc);
         wait_drain();
         check_i("vec_resp_count", n_resp, prev + 1);
         check_w("vec_rdata", last_rdata, vecs[v].exp_rdata);
`ifdef MAIN_MEM_RESP_RANGE_CHECK_EN
         check_b("vec_err", last_err, vecs[v].exp_err);
`endif
      end

      // req_valid held high with alternating addresses: one acceptance every LAT+1 cycles.
      nc;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0100;
      first = -1;
      for (int k = 0; k < 26; k++) begin
         smp;
         if (first < 0 && req_ready) first = cyc;
         if (first >= 0) begin
            check_b("b2b_req_ready", req_ready, ((cyc - first) % (LAT + 1)) == 0);
            check_b("b2b_busy", busy, ((cyc - first) % (LAT + 1)) != 0);
         end
         was = req_ready;
         nc;
         if (was) req_addr = req_addr ^ 32'h0000_0010;
      end
      req_valid = 1'b0;
      wait_drain();

      // Reset two cycles into a writeback: no strobe, storage untouched.
      do_req(1'b1, 32'h0000_0080, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, acc);
      nc; reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         smp;
         check_b("abort_busy", busy, 1'b0);
         check_b("abort_resp_valid", resp_valid, 1'b0);
         check_b("abort_req_ready", req_ready, 1'b0);
         nc;
      end
      sb.delete();
      reset = 1'b1;
      smp;
      check_b("abort_ready_after_reset", req_ready, 1'b1);
      do_req(1'b0, 32'h0000_0080, '0, acc);
      wait_drain();
      check_w("abort_prior_contents", last_rdata, pat(8));

      // LATENCY=1 instance: response the next cycle, next acceptance two cycles later.
      nc;
      l1_valid = 1'b1; l1_write = 1'b1; l1_addr = 32'h0000_0040;
      l1_wdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      smp;
      check_b("l1_accept_write", l1_ready, 1'b1);
      nc;
      l1_write = 1'b0; l1_wdata = '0;
      smp;
      check_b("l1_wr_resp_valid", l1_resp_valid, 1'b1);
      check_b("l1_busy_resp", l1_busy, 1'b1);
      check_b("l1_no_accept_in_resp", l1_ready, 1'b0);
      check_w("l1_wr_rdata_zero", l1_rdata, '0);
      nc;
      smp;
      check_b("l1_accept_read", l1_ready, 1'b1);
      check_b("l1_idle_resp_valid", l1_resp_valid, 1'b0);
      nc;
      l1_valid = 1'b0;
      smp;
      check_b("l1_rd_resp_valid", l1_resp_valid, 1'b1);
      check_w("l1_rd_rdata", l1_rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      nc;
      smp;
      check_b("l1_back_to_idle", l1_resp_valid, 1'b0);
      check_b("l1_ready_idle", l1_ready, 1'b1);

      check_i("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
